// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the 8-way round-robin arbiter.
// rr_pick scans from the pointer upward, modulo N_REQ, and returns the first set request.
package rr_arb_pkg;

    localparam int IDX_W = 3;
    localparam int N_REQ = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    // The result is only meaningful when r is non-zero.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [IDX_W-1:0] p);
        logic [IDX_W-1:0] w;
        logic [IDX_W-1:0] c;
        logic             found;
        w     = p;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            c = p + IDX_W'(k);
            if (!found && r[c]) begin
                w     = c;
                found = 1'b1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/idx_decoder.sv
// Combinational 3-to-8 decoder with an active-low enable.
// Output is all zero while disabled; no state, no latency.
module idx_decoder
    import rr_arb_pkg::*;
(
    input  logic [IDX_W-1:0] i_idx,
    input  logic             i_en_n,
    output logic [N_REQ-1:0] o_dec
);

    always_comb begin
        o_dec = '0;
        if (!i_en_n) begin
            o_dec[i_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with a hold limit; grant registered 1 cycle after req.
// No backpressure; ARB_GAP_EN inserts one dead cycle on every grant-to-grant handoff.
module rr_arbiter8
    import rr_arb_pkg::*;
#(
    parameter int HOLD_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    arb_state_t       r_state;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_idx;
    logic [7:0]       r_cnt;

    arb_state_t       w_state_nxt;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [7:0]       w_cnt_nxt;

    logic [N_REQ-1:0] w_others;
    logic             w_release;
    logic             w_preempt;
    logic [IDX_W-1:0] w_pick_req;
    logic [IDX_W-1:0] w_pick_oth;

    assign w_others   = req & ~(N_REQ'(1) << r_idx);
    assign w_release  = ~req[r_idx];
    assign w_preempt  = req[r_idx] & (|w_others) & (r_cnt == HOLD_LAST);
    assign w_pick_req = rr_pick(req, r_ptr);
    assign w_pick_oth = rr_pick(w_others, r_ptr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_state_nxt = GRANT;
                    w_idx_nxt   = w_pick_req;
                    w_ptr_nxt   = w_pick_req + IDX_W'(1);
                    w_cnt_nxt   = '0;
                end
            end
            GRANT: begin
                if (w_release || w_preempt) begin
                    if (|w_others) begin
`ifdef ARB_GAP_EN
                        w_state_nxt = GAP;
`else
                        w_state_nxt = GRANT;
                        w_idx_nxt   = w_pick_oth;
                        w_ptr_nxt   = w_pick_oth + IDX_W'(1);
                        w_cnt_nxt   = '0;
`endif
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (r_cnt != HOLD_LAST) begin
                    // Stops at the limit so a waiting requester preempts as soon as it appears.
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
`ifdef ARB_GAP_EN
            GAP: begin
                if (|req) begin
                    w_state_nxt = GRANT;
                    w_idx_nxt   = w_pick_req;
                    w_ptr_nxt   = w_pick_req + IDX_W'(1);
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
`endif
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign gnt_valid = (r_state == GRANT);
    assign gnt_idx   = r_idx;

    idx_decoder u_dec (
        .i_idx  (r_idx),
        .i_en_n (~gnt_valid),
        .o_dec  (gnt)
    );

endmodule
